// File: rtl/des_key_schedule.sv
// DES key schedule: turns a 64-bit key into the sixteen 48-bit round
// subkeys, presenting one subkey at a time behind a valid/ready handshake.
// Decrypt order is produced by running the C/D rotations backwards instead
// of storing the subkeys.
//
// The round output is 4 bits wide, so round 16 is presented as 4'h0.
// While subkey_valid is high, 0 means round 16. While subkey_valid is
// low, 0 means idle.
module des_key_schedule #(
  parameter int PARITY_CHK = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        decrypt,
  input  logic [63:0] key_in,
  input  logic        subkey_ready,
  output logic        subkey_valid,
  output logic [47:0] subkey,
  output logic [3:0]  round,
  output logic        busy,
  output logic        done,
  output logic        parity_err
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  // PC-1: DES key bit numbers (1 = key_in[63]) feeding C1..C28, then D1..D28
  localparam int PC1_TAB [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  // PC-2: CD bit numbers (1 = C1, 29 = D1) feeding subkey bits 1..48
  localparam int PC2_TAB [0:47] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  logic [0:0]  state_q, state_d;
  logic [27:0] c_q, c_d;
  logic [27:0] d_q, d_d;
  logic [47:0] subkey_q, subkey_d;
  logic [4:0]  round_q, round_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        dir_q, dir_d;
  logic        parity_q, parity_d;

  logic [55:0] cd0;
  logic [4:0]  nextRound;
  logic [4:0]  shiftIdx;
  logic        twoStep;
  logic [27:0] cNew, dNew;

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1_TAB[i]];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2_TAB[i]];
    return r;
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  // SHIFT[n] is 1 for rounds 1, 2, 9 and 16 and 2 everywhere else
  function automatic logic isTwoShift(input logic [4:0] n);
    return !(n == 5'd1 || n == 5'd2 || n == 5'd9 || n == 5'd16);
  endfunction

  // A key byte with even parity marks the whole key as bad
  function automatic logic keyParityErr(input logic [63:0] k);
    logic err;
    err = 1'b0;
    for (int b = 0; b < 8; b++) if (~^k[8*b +: 8]) err = 1'b1;
    return err;
  endfunction

  // Next-state logic: start in IDLE, advance one round per handshake in RUN
  always_comb begin
    state_d   = state_q;
    c_d       = c_q;
    d_d       = d_q;
    subkey_d  = subkey_q;
    round_d   = round_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dir_d     = dir_q;
    parity_d  = parity_q;
    cNew      = c_q;
    dNew      = d_q;
    cd0       = pc1(key_in);
    nextRound = round_q + 5'd1;
    // Decrypt walks the shift table backwards: entering round n undoes SHIFT[18-n]
    shiftIdx  = dir_q ? (5'd18 - nextRound) : nextRound;
    twoStep   = isTwoShift(shiftIdx);

    case (state_q)
      IDLE: begin
        if (start) begin
          dir_d = decrypt;
          // C16/D16 equal C0/D0 after 28 total shifts, so decrypt starts unrotated
          if (decrypt) begin
            cNew = cd0[55:28];
            dNew = cd0[27:0];
          end else begin
            cNew = rotl(cd0[55:28], 1'b0);
            dNew = rotl(cd0[27:0], 1'b0);
          end
          c_d      = cNew;
          d_d      = dNew;
          subkey_d = pc2({cNew, dNew});
          round_d  = 5'd1;
          valid_d  = 1'b1;
          busy_d   = 1'b1;
          parity_d = (PARITY_CHK != 0) ? keyParityErr(key_in) : 1'b0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (valid_q && subkey_ready) begin
          if (round_q == 5'd16) begin
            valid_d  = 1'b0;
            busy_d   = 1'b0;
            round_d  = 5'd0;
            subkey_d = '0;
            done_d   = 1'b1;
            state_d  = IDLE;
          end else begin
            if (dir_q) begin
              cNew = rotr(c_q, twoStep);
              dNew = rotr(d_q, twoStep);
            end else begin
              cNew = rotl(c_q, twoStep);
              dNew = rotl(d_q, twoStep);
            end
            c_d      = cNew;
            d_d      = dNew;
            subkey_d = pc2({cNew, dNew});
            round_d  = nextRound;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      c_q      <= '0;
      d_q      <= '0;
      subkey_q <= '0;
      round_q  <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dir_q    <= 1'b0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      c_q      <= c_d;
      d_q      <= d_d;
      subkey_q <= subkey_d;
      round_q  <= round_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dir_q    <= dir_d;
      parity_q <= parity_d;
    end
  end

  assign subkey_valid = valid_q;
  assign subkey       = subkey_q;
  assign round        = round_q[3:0];
  assign busy         = busy_q;
  assign done         = done_q;
  assign parity_err   = parity_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule using the classic 0x133457799BBCDFF1
// key, whose sixteen subkeys are tabulated below.
module tb_des_key_schedule;

  localparam logic [63:0] KEY_A   = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_BAD = 64'h133457799BBCDFF0;
  localparam logic [63:0] KEY_B   = 64'h0E329232EA6D0D73;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        decrypt;
  logic [63:0] key_in;
  logic        subkey_ready;
  logic        subkey_valid;
  logic [47:0] subkey;
  logic [3:0]  round;
  logic        busy;
  logic        done;
  logic        parity_err;

  int checkCount = 0;
  int errorCount = 0;
  logic [47:0] kTab [0:15];

  des_key_schedule #(.PARITY_CHK(1)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .decrypt(decrypt),
    .key_in(key_in),
    .subkey_ready(subkey_ready),
    .subkey_valid(subkey_valid),
    .subkey(subkey),
    .round(round),
    .busy(busy),
    .done(done),
    .parity_err(parity_err)
  );

  // 100 MHz-style free-running clock
  always #5 clk = ~clk;

  // Watchdog so a stuck run still ends with a report
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_valid"}, subkey_valid, 0);
    checkOutput({tag, "_subkey"}, subkey, 0);
    checkOutput({tag, "_round"}, round, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
  endtask

  task automatic checkPresented(input string tag, input int r, input logic dec);
    logic [3:0] expRound;
    expRound = r[3:0];
    checkOutput($sformatf("%s_valid_r%0d", tag, r), subkey_valid, 1);
    checkOutput($sformatf("%s_round_r%0d", tag, r), round, expRound);
    checkOutput($sformatf("%s_subkey_r%0d", tag, r), subkey,
                dec ? kTab[16-r] : kTab[r-1]);
    checkOutput($sformatf("%s_busy_r%0d", tag, r), busy, 1);
    checkOutput($sformatf("%s_done_r%0d", tag, r), done, 0);
  endtask

  task automatic checkDone(input string tag);
    checkOutput({tag, "_done_pulse"}, done, 1);
    checkOutput({tag, "_done_valid"}, subkey_valid, 0);
    checkOutput({tag, "_done_round"}, round, 0);
    checkOutput({tag, "_done_subkey"}, subkey, 0);
    checkOutput({tag, "_done_busy"}, busy, 0);
    @(negedge clk);
    checkOutput({tag, "_done_cleared"}, done, 0);
  endtask

  // Issue a one-cycle start; returns at the negedge where round 1 is visible
  task automatic applyStimulus(input logic [63:0] key, input logic dec);
    @(negedge clk);
    key_in  = key;
    decrypt = dec;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int expRound;
    int hsCount;
    int cycles;
    logic readyBit;

    kTab[0]  = 48'h1B02EFFC7072;
    kTab[1]  = 48'h79AED9DBC9E5;
    kTab[2]  = 48'h55FC8A42CF99;
    kTab[3]  = 48'h72ADD6DB351D;
    kTab[4]  = 48'h7CEC07EB53A8;
    kTab[5]  = 48'h63A53E507B2F;
    kTab[6]  = 48'hEC84B7F618BC;
    kTab[7]  = 48'hF78A3AC13BFB;
    kTab[8]  = 48'hE0DBEBEDE781;
    kTab[9]  = 48'hB1F347BA464F;
    kTab[10] = 48'h215FD3DED386;
    kTab[11] = 48'h7571F59467E9;
    kTab[12] = 48'h97C5D1FABA41;
    kTab[13] = 48'h5F43B7F2E73A;
    kTab[14] = 48'hBF918D3D3F0A;
    kTab[15] = 48'hCB3D8B0E17F5;

    reset        = 1'b0;
    start        = 1'b0;
    decrypt      = 1'b0;
    key_in       = '0;
    subkey_ready = 1'b1;
    repeat (2) @(negedge clk);
    checkIdle("reset");
    checkOutput("reset_parity", parity_err, 0);
    reset = 1'b1;

    // Encrypt order with ready held high
    applyStimulus(KEY_A, 1'b0);
    checkOutput("enc_parity", parity_err, 0);
    for (int r = 1; r <= 16; r++) begin
      checkPresented("enc", r, 1'b0);
      @(negedge clk);
    end
    checkDone("enc");
    checkIdle("enc_after");

    // Decrypt order: the encrypt table reversed
    applyStimulus(KEY_A, 1'b1);
    for (int r = 1; r <= 16; r++) begin
      checkPresented("dec", r, 1'b1);
      @(negedge clk);
    end
    checkDone("dec");

    // Backpressure: pseudo-random ready, rounds must hold and never skip
    applyStimulus(KEY_A, 1'b0);
    expRound = 1;
    hsCount  = 0;
    cycles   = 0;
    while (expRound <= 16 && cycles < 300) begin
      checkPresented("bp", expRound, 1'b0);
      readyBit = (cycles < 2) ? 1'b0 : 1'($urandom_range(0, 1));
      subkey_ready = readyBit;
      if (readyBit && subkey_valid) begin
        hsCount++;
        expRound++;
      end
      cycles++;
      @(negedge clk);
    end
    subkey_ready = 1'b1;
    checkOutput("bp_handshakes", hsCount, 16);
    checkDone("bp");

    // Start pulses during RUN (round 7 and the final handshake) are ignored
    applyStimulus(KEY_A, 1'b0);
    for (int r = 1; r <= 16; r++) begin
      checkPresented("ign", r, 1'b0);
      if (r == 7 || r == 16) begin
        start   = 1'b1;
        key_in  = KEY_B;
        decrypt = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checkDone("ign");
    checkIdle("ign_after");

    // Reset in the middle of round 9 abandons the schedule without done
    applyStimulus(KEY_A, 1'b0);
    for (int r = 1; r <= 9; r++) begin
      checkPresented("mid", r, 1'b0);
      if (r < 9) @(negedge clk);
    end
    reset = 1'b0;
    @(negedge clk);
    checkIdle("midrst");
    checkOutput("midrst_parity", parity_err, 0);
    reset = 1'b1;
    applyStimulus(KEY_A, 1'b0);
    for (int r = 1; r <= 16; r++) begin
      checkPresented("restart", r, 1'b0);
      @(negedge clk);
    end
    checkDone("restart");

    // Even-parity last byte flags parity_err; PC-1 drops parity bits so subkeys match
    applyStimulus(KEY_BAD, 1'b0);
    checkOutput("par_flag", parity_err, 1);
    for (int r = 1; r <= 16; r++) begin
      checkPresented("par", r, 1'b0);
      @(negedge clk);
    end
    checkDone("par");
    checkOutput("par_flag_held", parity_err, 1);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
- Generates the sixteen 48-bit DES round subkeys from a 64-bit key, one subkey per accepted handshake.
- Each subkey feeds the expansion/key-XOR stage directly upstream of the eight S-box lookup blocks.
  - subkey[47:42] feeds the S1 slice; subkey[23:18] feeds the S5 slice.
- Supports encrypt order (K1..K16) and decrypt order (K16..K1) without precomputation storage.

Parameters:
- PARITY_CHK, 1, when 1 checks odd parity of each key byte and drives parity_err; when 0, parity_err is tied to 0.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  begin a schedule; accepted only in IDLE
- decrypt  in  1  direction select, sampled with start; 1 = reverse subkey order
- key_in  in  64  DES key; key_in[63] = DES bit 1, key_in[0] = DES bit 64; parity bits included
- subkey_ready  in  1  downstream accepts the current subkey
- subkey_valid  out  1  subkey/round outputs are valid
- subkey  out  48  current round subkey; subkey[47] = PC-2 output bit 1
- round  out  4  round index 1..16 of the presented subkey (0 when idle)
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse after the round-16 subkey is accepted
- parity_err  out  1  registered parity flag for the key latched by the last accepted start

Behaviour:
- Reset (reset==0 at clk edge): state=IDLE; all outputs 0; C and D 28-bit registers cleared. Applies mid-operation; schedule abandoned, no done pulse.
- All outputs are registered. No combinational path from inputs to outputs.
- States: IDLE, RUN.
- IDLE:
  - If start==1: apply PC-1 to key_in to form C0 (28 bits) and D0 (28 bits). Latch decrypt into dir.
  - Encrypt start: C,D <= C0,D0 rotated left by SHIFT[1]=1.
  - Decrypt start: C,D <= C0,D0 unrotated, since C16=C0 after 28 total shifts.
  - subkey <= PC-2 of the new C,D; round <= 1; subkey_valid <= 1; busy <= 1; go to RUN.
  - parity_err <= 1 if any key byte has even parity (PARITY_CHK=1); the key is still processed.
- SHIFT[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- RUN: a handshake occurs when subkey_valid && subkey_ready at the clk edge.
  - No handshake: hold all outputs, C and D stable.
  - Handshake, round<16:
    - round <= round+1.
    - Encrypt: rotate C,D left by SHIFT[round+1].
    - Decrypt: rotate C,D right by SHIFT[18-(round+1)]; the rotate for round 2 uses SHIFT[16], the rotate for round 16 uses SHIFT[2].
    - subkey <= PC-2 of the rotated C,D, in the same edge.
  - Handshake, round==16: subkey_valid<=0, busy<=0, round<=0, subkey<=0, done<=1 for exactly one cycle, go to IDLE.
- start during RUN is ignored, including the final-handshake cycle. A new start is accepted the cycle after done at the earliest.
- decrypt and key_in changes during RUN have no effect.
- Latency:
  - start edge to first subkey_valid: 1 cycle.
  - Full schedule with subkey_ready held at 1: 16 valid cycles, then done.
- Rotations are modulo-28 circular within C and D independently. No bits cross between C and D.

Test Plan:
- Key 0x133457799BBCDFF1, decrypt=0, subkey_ready=1 -> round1 subkey 0x1B02EFFC7072, round16 subkey 0xCB3D8B0E17F5. done pulses on the cycle after the round-16 handshake; parity_err=0.
- Same key, decrypt=1 -> round1 subkey 0xCB3D8B0E17F5, round16 subkey 0x1B02EFFC7072. The full sequence equals the encrypt sequence reversed against a software model.
- Backpressure: encrypt run with subkey_ready toggled pseudo-randomly -> subkey and round are held while ready=0. No round is skipped or duplicated; exactly 16 handshakes occur.
- start pulsed during RUN at round 7 with a different key -> ignored; the remaining subkeys match the original key.
- reset deasserted-low at round 9 -> the next cycle has all outputs 0 and no done pulse. A new start then produces a correct K1.
- Key 0x133457799BBCDFF0 (last byte even parity) -> parity_err=1 from the cycle after start, and subkeys are still produced.
